// File: rtl/srs_pkg.sv
// Shared definitions for the sparse row streamer: FSM encoding, default
// parameter values and index-width helpers.
package srs_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        STREAM = 3'd2,
        WAIT   = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ROW_LEN    = 16;
    localparam int DEF_NUM_ROWS   = 16;
    localparam int DEF_VAL_DEPTH  = 256;

    // Width of an index into n entries; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width able to hold a count from 0 to n inclusive.
    function automatic int cnt_w(input int n);
        return idx_w(n) + 1;
    endfunction

endpackage

// File: rtl/srs_lead_one.sv
// Combinational lowest-set-bit finder and population count over one
// row mask; lead_idx is 0 when the mask is empty.
module srs_lead_one
    import srs_pkg::*;
#(
    parameter int ROW_LEN = DEF_ROW_LEN
) (
    input  logic [ROW_LEN-1:0]        mask,
    output logic [idx_w(ROW_LEN)-1:0] lead_idx,
    output logic [cnt_w(ROW_LEN)-1:0] count
);

    localparam int IW = idx_w(ROW_LEN);
    localparam int NW = cnt_w(ROW_LEN);

    // Scanning from the top down lets the lowest set bit win.
    always_comb begin
        lead_idx = '0;
        count    = '0;
        for (int i = ROW_LEN - 1; i >= 0; i--) begin
            if (mask[i]) begin
                lead_idx = IW'(i);
                count    = count + NW'(1);
            end
        end
    end

endmodule

// File: rtl/sparse_row_streamer.sv
// Streams bitmap-compressed activation rows in serial (one value per beat)
// or parallel (dense row) form. Define SRS_ZERO_SKIP_EN to skip all-zero rows.
module sparse_row_streamer
    import srs_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ROW_LEN    = DEF_ROW_LEN,
    parameter int NUM_ROWS   = DEF_NUM_ROWS,
    parameter int VAL_DEPTH  = DEF_VAL_DEPTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_req_flag,
    input  logic [ROW_LEN-1:0]            wr_data_flag,
    input  logic                          wr_req_act,
    input  logic [DATA_WIDTH-1:0]         wr_data_act,
    input  logic                          mode,
    input  logic                          start,
    input  logic                          out_ready,
    input  logic                          row_ack,
    output logic                          out_valid,
    output logic [DATA_WIDTH-1:0]         serial_out,
    output logic [idx_w(ROW_LEN)-1:0]     col_index,
    output logic [ROW_LEN*DATA_WIDTH-1:0] parallel_out,
    output logic [idx_w(NUM_ROWS)-1:0]    row_index,
    output logic [cnt_w(ROW_LEN)-1:0]     row_val_num,
    output logic                          zero_flag,
    output logic [2:0]                    state,
    output logic                          busy,
    output logic                          done
);

    localparam int CW = idx_w(ROW_LEN);
    localparam int RW = idx_w(NUM_ROWS);
    localparam int VW = idx_w(VAL_DEPTH);
    localparam int NW = cnt_w(ROW_LEN);

    logic [ROW_LEN-1:0]    flag_mem [NUM_ROWS];
    logic [DATA_WIDTH-1:0] val_mem  [VAL_DEPTH];

    state_t                    state_q;
    logic                      mode_q;
    logic [RW-1:0]             flag_wr_ptr;
    logic [VW-1:0]             val_wr_ptr;
    logic [VW-1:0]             rd_ptr;
    logic [ROW_LEN-1:0]        mask;
    logic [ROW_LEN*DATA_WIDTH-1:0] dense;

    logic [ROW_LEN-1:0]    flag_word;
    logic [ROW_LEN-1:0]    mask_next;
    logic [ROW_LEN-1:0]    lead_in;
    logic [CW-1:0]         lead_idx;
    logic [NW-1:0]         pop;
    logic [VW-1:0]         rd_ptr_inc;
    logic [DATA_WIDTH-1:0] rd_val;
    logic [DATA_WIDTH-1:0] next_val;
    logic                  last_row;

    assign flag_word  = flag_mem[row_index];
    assign mask_next  = mask & (mask - 1'b1);
    assign rd_ptr_inc = (rd_ptr == VW'(VAL_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
    assign rd_val     = val_mem[rd_ptr];
    assign next_val   = val_mem[rd_ptr_inc];
    assign last_row   = (row_index == RW'(NUM_ROWS - 1));

    // LOAD needs the new row's first position; serial STREAM needs the position
    // after the current beat; parallel STREAM fills the current lowest position.
    assign lead_in = (state_q == LOAD) ? flag_word : (mode_q ? mask : mask_next);

    srs_lead_one #(.ROW_LEN(ROW_LEN)) u_lead_one (
        .mask     (lead_in),
        .lead_idx (lead_idx),
        .count    (pop)
    );

    assign state        = state_q;
    assign busy         = (state_q != IDLE);
    assign parallel_out = dense;

    // RAM contents survive reset; only the pointers are cleared.
    always_ff @(posedge clk) begin
        if (reset && state_q == IDLE) begin
            if (wr_req_flag) flag_mem[flag_wr_ptr] <= wr_data_flag;
            if (wr_req_act)  val_mem[val_wr_ptr]   <= wr_data_act;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            flag_wr_ptr <= '0;
            val_wr_ptr  <= '0;
            rd_ptr      <= '0;
            mask        <= '0;
            dense       <= '0;
            row_index   <= '0;
            row_val_num <= '0;
            zero_flag   <= 1'b0;
            out_valid   <= 1'b0;
            serial_out  <= '0;
            col_index   <= '0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (wr_req_flag)
                        flag_wr_ptr <= (flag_wr_ptr == RW'(NUM_ROWS - 1)) ? '0 : flag_wr_ptr + 1'b1;
                    if (wr_req_act)
                        val_wr_ptr <= (val_wr_ptr == VW'(VAL_DEPTH - 1)) ? '0 : val_wr_ptr + 1'b1;
                    if (start) begin
                        mode_q    <= mode;
                        row_index <= '0;
                        rd_ptr    <= '0;
                        state_q   <= LOAD;
                    end
                end
                LOAD: begin
                    row_val_num <= pop;
                    zero_flag   <= (pop == '0);
                    mask        <= flag_word;
                    dense       <= '0;
                    state_q     <= STREAM;
                    if (mode_q) begin
                        out_valid <= (flag_word == '0);
                    end else if (flag_word != '0) begin
                        out_valid  <= 1'b1;
                        serial_out <= rd_val;
                        col_index  <= lead_idx;
                    end
`ifdef SRS_ZERO_SKIP_EN
                    if (flag_word == '0) begin
                        out_valid <= 1'b0;
                        if (last_row) begin
                            done    <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            row_index <= row_index + 1'b1;
                            state_q   <= LOAD;
                        end
                    end
`endif
                end
                STREAM: begin
                    if (mode_q) begin
                        if (mask != '0) begin
                            for (int i = 0; i < ROW_LEN; i++) begin
                                if (CW'(i) == lead_idx)
                                    dense[i*DATA_WIDTH +: DATA_WIDTH] <= rd_val;
                            end
                            rd_ptr <= rd_ptr_inc;
                            mask   <= mask_next;
                            if (mask_next == '0) out_valid <= 1'b1;
                        end else if (out_ready) begin
                            out_valid <= 1'b0;
                            state_q   <= WAIT;
                        end
                    end else begin
                        if (mask == '0) begin
                            state_q <= WAIT;
                        end else if (out_ready) begin
                            rd_ptr <= rd_ptr_inc;
                            mask   <= mask_next;
                            if (mask_next == '0) begin
                                out_valid <= 1'b0;
                                state_q   <= WAIT;
                            end else begin
                                serial_out <= next_val;
                                col_index  <= lead_idx;
                            end
                        end
                    end
                end
                WAIT: begin
                    if (row_ack) begin
                        if (last_row) begin
                            done    <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            row_index <= row_index + 1'b1;
                            state_q   <= LOAD;
                        end
                    end
                end
                DONE: begin
                    flag_wr_ptr <= '0;
                    val_wr_ptr  <= '0;
                    zero_flag   <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sparse_row_streamer.sv
// Randomized scoreboard bench for sparse_row_streamer: a row/value model
// predicts every beat and every WAIT visit; a monitor compares them.
module tb_sparse_row_streamer;

    localparam int DW = 8;
    localparam int RL = 16;
    localparam int NR = 16;
    localparam int VD = 256;
    localparam int BUDGET = 5000;

    logic              clk;
    logic              reset;
    logic              wr_req_flag;
    logic [RL-1:0]     wr_data_flag;
    logic              wr_req_act;
    logic [DW-1:0]     wr_data_act;
    logic              mode;
    logic              start;
    logic              out_ready;
    logic              row_ack;
    logic              out_valid;
    logic [DW-1:0]     serial_out;
    logic [3:0]        col_index;
    logic [RL*DW-1:0]  parallel_out;
    logic [3:0]        row_index;
    logic [4:0]        row_val_num;
    logic              zero_flag;
    logic [2:0]        state;
    logic              busy;
    logic              done;

    sparse_row_streamer #(
        .DATA_WIDTH (DW),
        .ROW_LEN    (RL),
        .NUM_ROWS   (NR),
        .VAL_DEPTH  (VD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_req_flag  (wr_req_flag),
        .wr_data_flag (wr_data_flag),
        .wr_req_act   (wr_req_act),
        .wr_data_act  (wr_data_act),
        .mode         (mode),
        .start        (start),
        .out_ready    (out_ready),
        .row_ack      (row_ack),
        .out_valid    (out_valid),
        .serial_out   (serial_out),
        .col_index    (col_index),
        .parallel_out (parallel_out),
        .row_index    (row_index),
        .row_val_num  (row_val_num),
        .zero_flag    (zero_flag),
        .state        (state),
        .busy         (busy),
        .done         (done)
    );

    typedef struct {
        int             row;
        int             col;
        logic [DW-1:0]  val;
        int             rvn;
        logic [RL*DW-1:0] dense;
    } beat_t;

    typedef struct {
        int row;
        int rvn;
        int zero;
    } wait_t;

    beat_t         exp_q[$];
    wait_t         wait_q[$];
    logic [RL-1:0] flags [NR];
    logic [DW-1:0] vals[$];

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int since_load = 0;
    bit drive_en = 0;
    bit cur_mode = 0;
    logic [2:0] prev_state = 3'd0;
    logic prev_valid = 1'b0;
    beat_t mon_b;
    wait_t mon_w;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [RL*DW-1:0] actual,
                               input logic [RL*DW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Data set: row 0 is the documented 0x0085 example, row 5 is empty,
    // row 3 is guaranteed non-empty so the abort test has a STREAM to hit.
    task automatic build_data();
        int total;
        vals.delete();
        total = 0;
        for (int r = 0; r < NR; r++) begin
            flags[r] = RL'($urandom & $urandom);
            if (r == 0) flags[r] = 16'h0085;
            if (r == 5) flags[r] = 16'h0000;
            if (r == 3) flags[r] = flags[r] | 16'h0010;
            total += $countones(flags[r]);
        end
        vals.push_back(8'h11);
        vals.push_back(8'h22);
        vals.push_back(8'h33);
        for (int i = 3; i < total; i++) vals.push_back(DW'($urandom_range(1, 255)));
    endtask

    task automatic build_model(input bit m);
        int ptr;
        int n;
        beat_t b;
        wait_t w;
        exp_q.delete();
        wait_q.delete();
        ptr = 0;
        for (int r = 0; r < NR; r++) begin
            n = $countones(flags[r]);
            b.row = r;
            b.rvn = n;
            b.col = 0;
            b.val = '0;
            b.dense = '0;
            for (int c = 0; c < RL; c++) begin
                if (flags[r][c]) begin
                    if (!m) begin
                        b.col = c;
                        b.val = vals[ptr];
                        exp_q.push_back(b);
                    end else begin
                        b.dense[c*DW +: DW] = vals[ptr];
                    end
                    ptr++;
                end
            end
            if (m) exp_q.push_back(b);
            w.row = r;
            w.rvn = n;
            w.zero = (n == 0) ? 1 : 0;
`ifdef SRS_ZERO_SKIP_EN
            if (n != 0)
`endif
            wait_q.push_back(w);
        end
    endtask

    // Flags and values go in side by side so simultaneous writes are exercised.
    task automatic applyStimulus();
        int n;
        n = (vals.size() > NR) ? vals.size() : NR;
        for (int i = 0; i < n; i++) begin
            wr_req_flag  = (i < NR);
            wr_data_flag = (i < NR) ? flags[i] : RL'($urandom);
            wr_req_act   = (i < vals.size());
            wr_data_act  = (i < vals.size()) ? vals[i] : DW'($urandom);
            @(posedge clk);
            #1;
        end
        wr_req_flag = 1'b0;
        wr_req_act  = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        checkOutput({tag, "_state"}, state, 0);
        checkOutput({tag, "_out_valid"}, out_valid, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_serial_out"}, serial_out, 0);
        checkOutput({tag, "_col_index"}, col_index, 0);
        checkOutput({tag, "_parallel_out"}, parallel_out, 0);
        checkOutput({tag, "_row_index"}, row_index, 0);
        checkOutput({tag, "_row_val_num"}, row_val_num, 0);
        checkOutput({tag, "_zero_flag"}, zero_flag, 0);
    endtask

    task automatic run_pass(input bit m);
        int cyc;
        cur_mode = m;
        build_model(m);
        done_cnt = 0;
        drive_en = 1;
        mode = m;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        while (state != 3'd0 && cyc < BUDGET) begin
            mode = 1'($urandom_range(0, 1));
            if (state != 3'd4) begin
                start        = ($urandom_range(0, 5) == 0);
                wr_req_flag  = 1'($urandom_range(0, 1));
                wr_data_flag = RL'($urandom);
                wr_req_act   = 1'($urandom_range(0, 1));
                wr_data_act  = DW'($urandom);
            end else begin
                start       = 1'b0;
                wr_req_flag = 1'b0;
                wr_req_act  = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        wr_req_flag = 1'b0;
        wr_req_act = 1'b0;
        drive_en = 0;
        checkOutput(m ? "par_pass_in_budget" : "ser_pass_in_budget", cyc < BUDGET, 1);
        checkOutput(m ? "par_done_count" : "ser_done_count", done_cnt, 1);
        checkOutput(m ? "par_beats_left" : "ser_beats_left", exp_q.size(), 0);
        checkOutput(m ? "par_waits_left" : "ser_waits_left", wait_q.size(), 0);
        checkOutput("busy_after_pass", busy, 0);
    endtask

    // Consumer: random backpressure and row_ack, including acks outside WAIT.
    always @(posedge clk) begin
        #1;
        if (drive_en) begin
            out_ready = ($urandom_range(0, 3) != 0);
            row_ack   = ($urandom_range(0, 2) == 0);
        end else begin
            out_ready = 1'b0;
            row_ack   = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            if (state == 3'd1) since_load = 0;
            else since_load++;
            if (done) begin
                done_cnt++;
                checkOutput("done_in_state4", state, 4);
            end
            if (state == 3'd3 && prev_state != 3'd3) begin
                if (wait_q.size() == 0) begin
                    checkOutput("unexpected_wait", state, 0);
                end else begin
                    mon_w = wait_q.pop_front();
                    checkOutput("wait_row_index", row_index, mon_w.row);
                    checkOutput("wait_zero_flag", zero_flag, mon_w.zero);
                    checkOutput("wait_row_val_num", row_val_num, mon_w.rvn);
                end
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_beat", out_valid, 0);
                end else begin
                    mon_b = exp_q[0];
                    checkOutput("beat_row_index", row_index, mon_b.row);
                    checkOutput("beat_row_val_num", row_val_num, mon_b.rvn);
                    if (cur_mode) begin
                        checkOutput("parallel_out", parallel_out, mon_b.dense);
                        if (!prev_valid) checkOutput("par_latency", since_load, mon_b.rvn + 1);
                    end else begin
                        checkOutput("serial_out", serial_out, mon_b.val);
                        checkOutput("col_index", col_index, mon_b.col);
                    end
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            prev_state = state;
            prev_valid = out_valid;
        end else begin
            prev_state = 3'd0;
            prev_valid = 1'b0;
        end
    end

    initial begin
        int cyc;
        reset = 1'b0;
        wr_req_flag = 1'b0;
        wr_data_flag = '0;
        wr_req_act = 1'b0;
        wr_data_act = '0;
        mode = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b1;
        @(posedge clk);
        #1;

        build_data();
        applyStimulus();
        run_pass(1'b0);
        run_pass(1'b1);

        // Abort a serial pass during row 3 and make sure it restarts cleanly.
        cur_mode = 0;
        build_model(1'b0);
        done_cnt = 0;
        drive_en = 1;
        mode = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        while (!(state == 3'd2 && row_index == 4'd3) && cyc < BUDGET) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checkOutput("reach_row3_stream", cyc < BUDGET, 1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        wait_q.delete();
        drive_en = 0;
        check_reset_outputs("abort");
        checkOutput("abort_no_done", done_cnt, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        run_pass(1'b0);
        run_pass(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sparse_row_streamer.md
SPARSE_ROW_STREAMER -- requirements
Module: sparse_row_streamer

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of one activation value.
REQ-002 Parameter ROW_LEN, default 16: positions per row; width of one flag bitmap.
REQ-003 Parameter NUM_ROWS, default 16: rows per pass; depth of flag RAM.
REQ-004 Parameter VAL_DEPTH, default 256: depth of compressed value RAM.
REQ-005 Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- wr_req_flag  in  1  write one row bitmap.
- wr_data_flag  in  ROW_LEN  row bitmap; bit i = position i nonzero.
- wr_req_act  in  1  write one compressed nonzero value.
- wr_data_act  in  DATA_WIDTH  nonzero value, row-major order.
- mode  in  1  0 = serial, 1 = parallel; sampled on start.
- start  in  1  begin one pass over NUM_ROWS rows.
- out_ready  in  1  consumer accepts the current output.
- row_ack  in  1  consumer finished the current row.
- out_valid  out  1  output beat valid.
- serial_out  out  DATA_WIDTH  value (serial mode).
- col_index  out  clog2(ROW_LEN)  position of serial_out.
- parallel_out  out  ROW_LEN*DATA_WIDTH  dense row, zeros refilled (parallel mode).
- row_index  out  clog2(NUM_ROWS)  current row.
- row_val_num  out  clog2(ROW_LEN)+1  nonzero count of current row.
- zero_flag  out  1  current row is all-zero.
- state  out  3  FSM state code.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse, pass complete.

Function
REQ-006 Writes are accepted only in IDLE; each accepted write stores at its pointer, then increments it; flag pointer wraps at NUM_ROWS, value pointer at VAL_DEPTH; simultaneous flag and value writes are both accepted.
REQ-007 States: IDLE=0, LOAD=1, STREAM=2, WAIT=3, DONE=4.
REQ-008 IDLE->LOAD on start: latch mode; row_index=0; value read pointer=0; start outside IDLE is ignored.
REQ-009 LOAD (1 cycle): read flag[row_index]; row_val_num=popcount; zero_flag=(popcount==0); load remaining-bit mask; ->STREAM.
REQ-010 Serial STREAM: out_valid=1; serial_out=value[rd_ptr]; col_index=lowest set bit of mask; on out_valid&&out_ready clear that bit and increment rd_ptr; after the last accepted beat ->WAIT; outputs hold stable while out_ready=0.
REQ-011 Parallel STREAM: one value per cycle written into dense row register at lowest set bit, no handshake; once mask empty, out_valid=1 with parallel_out; on out_ready ->WAIT; latency LOAD to out_valid = row_val_num+1 cycles.
REQ-012 WAIT: out_valid=0; on row_ack, if row_index==NUM_ROWS-1 ->DONE, else row_index+1 and ->LOAD; row_ack in any other state is ignored.
REQ-013 DONE (1 cycle): done=1; write pointers cleared to 0; ->IDLE.
REQ-014 Zero row without skip: serial mode emits no beat, STREAM->WAIT in 1 cycle; parallel mode presents an all-zero parallel_out.
REQ-015 Dense parallel register is cleared on every LOAD.

Reset
REQ-016 With reset low at a clock edge: state=IDLE; all pointers, row_index, row_val_num, mask, dense register =0; out_valid, zero_flag, busy, done, serial_out, col_index, parallel_out =0; RAM contents are not cleared.
REQ-017 Reset mid-pass aborts immediately; no done pulse; next start begins at row 0.

Configuration
REQ-018 Macro SRS_ZERO_SKIP_EN: when defined, an all-zero row in LOAD pulses zero_flag for 1 cycle and goes directly to the next LOAD (or DONE), with no beat and no row_ack required; when undefined, REQ-014 applies and row_ack is required for every row.

Structure
REQ-019 Package srs_pkg holds state encodings, default parameter values and index-width functions.
REQ-020 One sub-module srs_lead_one: combinational lowest-set-bit index and popcount of a ROW_LEN mask.

Verification
REQ-021 Serial, row0 flag 0x0085, values 0x11,0x22,0x33, out_ready=1 -> beats (0x11,col0),(0x22,col2),(0x33,col7), row_val_num=3, then WAIT.
REQ-022 Parallel, same row -> after 4 cycles parallel_out has 0x11@0, 0x22@2, 0x33@7, zeros elsewhere; single beat.
REQ-023 out_ready low 3 cycles mid-row -> serial_out/col_index held, no value lost or duplicated.
REQ-024 Row 5 flag 0x0000 -> with SRS_ZERO_SKIP_EN one-cycle zero_flag, no row_ack needed; without it WAIT until row_ack.
REQ-025 All 16 rows acked -> done pulses once in state 4, then IDLE; writes during the pass ignored.
REQ-026 reset low during STREAM of row 3 -> all outputs 0, state 0; subsequent start restarts at row 0.
